// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and oversampling tick constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam logic [3:0] MID_TICK  = 4'd7;
  localparam logic [3:0] LAST_TICK = 4'd15;

endpackage

// File: rtl/fifo.sv
// Small show-ahead FIFO; a write while full is accepted only when a read frees the slot in the same cycle.
module fifo #(
  parameter int DATA_SIZE      = 8,
  parameter int ADDR_SPACE_EXP = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_to_fifo,
  input  logic                 read_from_fifo,
  input  logic [DATA_SIZE-1:0] write_data_in,
  output logic [DATA_SIZE-1:0] read_data_out,
  output logic                 empty,
  output logic                 full
);

  localparam int DEPTH = 2 ** ADDR_SPACE_EXP;

  logic [DATA_SIZE-1:0]      r_mem [DEPTH];
  logic [ADDR_SPACE_EXP-1:0] r_wr_ptr;
  logic [ADDR_SPACE_EXP-1:0] r_rd_ptr;
  logic [ADDR_SPACE_EXP:0]   r_count;
  logic                      w_rd;
  logic                      w_wr;

  assign empty = (r_count == '0);
  assign full  = (r_count == (ADDR_SPACE_EXP + 1)'(DEPTH));
  assign w_rd  = read_from_fifo & ~empty;
  assign w_wr  = write_to_fifo & (~full | w_rd);

  // Gating with empty keeps the head at zero after reset without clearing the storage.
  assign read_data_out = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (ADDR_SPACE_EXP)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (ADDR_SPACE_EXP)'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (ADDR_SPACE_EXP + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_SPACE_EXP + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; only pointers and count carry state that must be defined after reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= write_data_in;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampling FSM with start/stop validation, Rx FIFO and sticky error flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DBITS    = 8,
  parameter int SB_TICK  = 16,
  parameter int FIFO_EXP = 2
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx,
  input  logic             sample_tick,
  input  logic             read_uart,
  input  logic             clr_err,
  output logic [DBITS-1:0] read_data,
  output logic             rx_empty,
  output logic             rx_full,
  output logic             frame_err,
  output logic             overrun
);

  localparam int              BW        = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam logic [BW-1:0]   LAST_BIT  = BW'(DBITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(SB_TICK - 1);

  rx_state_t        r_state;
  logic             r_sync_meta;
  logic             r_rx_sync;
  logic [3:0]       r_tick_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [DBITS-1:0] r_shift;
  logic             r_push;
  logic             r_frame_err;
  logic             r_overrun;
  logic             w_push_ok;
  logic             w_pop;
  logic             w_drop;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_sync_meta <= 1'b1;
      r_rx_sync   <= 1'b1;
    end else begin
      r_sync_meta <= rx;
      r_rx_sync   <= r_sync_meta;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_push <= 1'b0;
      // NOTE: a later non-blocking assignment in the same block wins, so a new framing error overrides clr_err.
      if (clr_err) r_frame_err <= 1'b0;
      if (sample_tick) begin
        case (r_state)
          IDLE: begin
            if (!r_rx_sync) begin
              r_state    <= START;
              r_tick_cnt <= '0;
            end
          end
          START: begin
            if (r_tick_cnt == MID_TICK) begin
              if (!r_rx_sync) begin
                r_state    <= DATA;
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          DATA: begin
            if (r_tick_cnt == LAST_TICK) begin
              r_shift    <= {r_rx_sync, r_shift[DBITS-1:1]};
              r_tick_cnt <= '0;
              if (r_bit_cnt == LAST_BIT) r_state <= STOP;
              else                       r_bit_cnt <= r_bit_cnt + BW'(1);
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          STOP: begin
            if (r_tick_cnt == STOP_LAST) begin
              r_tick_cnt <= '0;
              if (r_rx_sync) begin
                r_push  <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= WAIT_IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          WAIT_IDLE: begin
            if (r_rx_sync) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // A full FIFO still takes the word when the user pops in the same cycle.
  assign w_pop     = read_uart & ~rx_empty;
  assign w_push_ok = r_push & (~rx_full | read_uart);
  assign w_drop    = r_push & ~w_push_ok;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)        r_overrun <= 1'b0;
    else if (w_drop)  r_overrun <= 1'b1;
    else if (clr_err) r_overrun <= 1'b0;
  end

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

  fifo #(
    .DATA_SIZE     (DBITS),
    .ADDR_SPACE_EXP(FIFO_EXP)
  ) FIFO_RX_UNIT (
    .clk           (clk_100MHz),
    .reset         (reset),
    .write_to_fifo (w_push_ok),
    .read_from_fifo(w_pop),
    .write_data_in (r_shift),
    .read_data_out (read_data),
    .empty         (rx_empty),
    .full          (rx_full)
  );

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: 8N1 frames at 16x oversampling, scoreboard queue of expected words.
`timescale 1ns/1ps
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int CLK_P = 10;
  localparam int BIT_CLKS = 64;

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic       rx;
  logic       sample_tick;
  logic       read_uart;
  logic       clr_err;
  logic [7:0] read_data;
  logic       rx_empty;
  logic       rx_full;
  logic       frame_err;
  logic       overrun;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  time        t_last_tick = 0;
  time        fall_dt = 0;
  int         fall_cnt = 0;

  uart_rx_core #(.DBITS(8), .SB_TICK(16), .FIFO_EXP(2)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .rx         (rx),
    .sample_tick(sample_tick),
    .read_uart  (read_uart),
    .clr_err    (clr_err),
    .read_data  (read_data),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial forever #(CLK_P / 2) clk_100MHz = ~clk_100MHz;

  // One tick every 4 clocks, so one bit time is 64 clocks.
  initial begin
    int phase;
    phase = 0;
    sample_tick = 1'b0;
    forever begin
      @(negedge clk_100MHz);
      phase = (phase + 1) % 4;
      sample_tick = (phase == 0);
      if (sample_tick) t_last_tick = $time;
    end
  end

  // Records when rx_empty falls relative to the most recent tick.
  initial begin
    logic prev_empty;
    prev_empty = 1'b1;
    forever begin
      @(negedge clk_100MHz);
      if (prev_empty && !rx_empty) begin
        fall_cnt++;
        fall_dt = $time - t_last_tick;
      end
      prev_empty = rx_empty;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk_100MHz);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk_100MHz);
    end
    rx = stop_bit;
    repeat (BIT_CLKS) @(negedge clk_100MHz);
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk_100MHz);
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_nonempty"}, 32'(rx_empty), 32'd0);
    if (exp_q.size() == 0) check({tag, "_sb_underflow"}, 32'd1, 32'd0);
    else                   check(tag, 32'(read_data), 32'(exp_q.pop_front()));
    read_uart = 1'b1;
    @(negedge clk_100MHz);
    read_uart = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk_100MHz);
    clr_err = 1'b0;
  endtask

  initial begin
    int f0;
    bit found;
    reset = 1'b1;
    rx = 1'b1;
    read_uart = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    reset = 1'b0;
    @(negedge clk_100MHz);
    check("rst_empty", 32'(rx_empty), 32'd1);
    check("rst_full", 32'(rx_full), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_data", 32'(read_data), 32'd0);
    idle_bits(1);

    // Single good frame
    f0 = fall_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle_bits(1);
    check("a5_fall", 32'(fall_cnt - f0), 32'd1);
    check("a5_latency", 32'(fall_dt), 32'(2 * CLK_P));
    check("a5_ferr", 32'(frame_err), 32'd0);
    pop_check("a5_data");
    check("a5_empty_after_pop", 32'(rx_empty), 32'd1);

    // Short low glitch is rejected at mid start bit
    rx = 1'b0;
    repeat (20) @(negedge clk_100MHz);
    idle_bits(2);
    check("glitch_state", 32'(dut.r_state), 32'(IDLE));
    check("glitch_empty", 32'(rx_empty), 32'd1);
    check("glitch_ferr", 32'(frame_err), 32'd0);
    check("glitch_ovr", 32'(overrun), 32'd0);

    // Framing error, then a good frame, then clear
    send_frame(8'h3C, 1'b0);
    idle_bits(1);
    check("fe_flag", 32'(frame_err), 32'd1);
    check("fe_empty", 32'(rx_empty), 32'd1);
    check("fe_ovr", 32'(overrun), 32'd0);
    f0 = fall_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle_bits(1);
    check("fe55_latency", 32'(fall_dt), 32'(2 * CLK_P));
    check("fe55_fall", 32'(fall_cnt - f0), 32'd1);
    check("fe_sticky", 32'(frame_err), 32'd1);
    pop_check("fe55_data");
    pulse_clr();
    check("fe_cleared", 32'(frame_err), 32'd0);

    // Overrun: fifth word dropped
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
      if (v == 4) begin
        idle_bits(1);
        check("ovr_full4", 32'(rx_full), 32'd1);
        check("ovr_none4", 32'(overrun), 32'd0);
      end
    end
    idle_bits(1);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_full5", 32'(rx_full), 32'd1);
    for (int k = 0; k < 4; k++) pop_check("ovr_data");
    check("ovr_drained", 32'(rx_empty), 32'd1);
    check("ovr_sb_empty", 32'(exp_q.size()), 32'd0);
    pulse_clr();
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Full FIFO with a pop in the push cycle
    for (int v = 1; v <= 4; v++) begin
      exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
    end
    idle_bits(1);
    check("sim_full", 32'(rx_full), 32'd1);
    exp_q.push_back(8'h66);
    found = 1'b0;
    fork
      send_frame(8'h66, 1'b1);
      begin
        for (int c = 0; c < 12 * BIT_CLKS; c++) begin
          @(negedge clk_100MHz);
          if (dut.r_push === 1'b1) begin
            found = 1'b1;
            break;
          end
        end
        if (found) pop_check("sim_pop_in_push");
      end
    join
    check("sim_push_seen", 32'(found), 32'd1);
    idle_bits(1);
    check("sim_ovr", 32'(overrun), 32'd0);
    check("sim_still_full", 32'(rx_full), 32'd1);
    for (int k = 0; k < 4; k++) pop_check("sim_data");
    check("sim_drained", 32'(rx_empty), 32'd1);

    // Reset in the middle of DATA bit 3, with a word stored and frame_err set
    send_frame(8'h77, 1'b1);
    send_frame(8'h3C, 1'b0);
    idle_bits(1);
    check("mr_pre_word", 32'(rx_empty), 32'd0);
    check("mr_pre_ferr", 32'(frame_err), 32'd1);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk_100MHz);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk_100MHz);
    end
    repeat (BIT_CLKS / 2) @(negedge clk_100MHz);
    check("mr_pre_state", 32'(dut.r_state), 32'(DATA));
    reset = 1'b1;
    #1;
    check("mr_empty", 32'(rx_empty), 32'd1);
    check("mr_full", 32'(rx_full), 32'd0);
    check("mr_ferr", 32'(frame_err), 32'd0);
    check("mr_ovr", 32'(overrun), 32'd0);
    check("mr_data", 32'(read_data), 32'd0);
    check("mr_state", 32'(dut.r_state), 32'(IDLE));
    exp_q.delete();
    rx = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    reset = 1'b0;
    idle_bits(2);
    f0 = fall_cnt;
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1);
    idle_bits(1);
    check("f0_fall", 32'(fall_cnt - f0), 32'd1);
    check("f0_latency", 32'(fall_dt), 32'(2 * CLK_P));
    pop_check("f0_data");
    check("f0_empty", 32'(rx_empty), 32'd1);
    check("f0_ferr", 32'(frame_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Receive-side UART core, the counterpart of the existing transmit path. It oversamples the serial input using the shared baud-rate `sample_tick`, validates start and stop bits, and assembles LSB-first data words. Each good word is pushed into a local Rx FIFO, which the user logic drains with `read_uart`. Framing and overrun errors are reported as sticky flags.

Parameters:
DBITS, 8, data bits per word
SB_TICK, 16, oversampling ticks spent in the stop bit (16 = one stop bit)
FIFO_EXP, 2, Rx FIFO depth exponent (depth 2^FIFO_EXP = 4)

Ports:
clk_100MHz  input  1  system clock, single clock domain
reset  input  1  asynchronous, active-high reset
rx  input  1  serial data in, asynchronous to clk_100MHz, idle high
sample_tick  input  1  one-cycle pulse at 16x baud, from baud_rate_generator
read_uart  input  1  single-cycle pop request
clr_err  input  1  single-cycle clear of the sticky error flags
read_data  output  DBITS  FIFO head word (show-ahead), valid while rx_empty=0
rx_empty  output  1  FIFO holds no words
rx_full  output  1  FIFO holds 2^FIFO_EXP words
frame_err  output  1  sticky: a stop bit was sampled low
overrun  output  1  sticky: a complete good word was dropped because the FIFO was full

Behaviour:
- Reset values: rx_sync=1, state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0, FIFO empty, rx_empty=1, rx_full=0, frame_err=0, overrun=0, read_data=0.
- Reset asserted mid-frame aborts the frame, empties the FIFO and clears both flags.
- Input synchroniser: rx passes through a 2-flop synchroniser (rx_sync). All FSM decisions use rx_sync only.
- tick_cnt is 4 bits and counts sample_tick pulses only. Clock cycles without a tick leave all FSM state unchanged.
- IDLE:
  - rx_sync==0 -> START, tick_cnt=0.
- START:
  - On each tick with tick_cnt==7 (mid start bit): if rx_sync==0 -> DATA with tick_cnt=0 and bit_cnt=0; else -> IDLE (glitch rejected, no flag).
  - On other ticks: tick_cnt++.
- DATA:
  - On each tick with tick_cnt==15: shift rx_sync in at the MSB and shift right (LSB-first line order), tick_cnt=0.
  - If bit_cnt==DBITS-1 -> STOP, else bit_cnt++.
- STOP:
  - On each tick with tick_cnt==SB_TICK-1, sample rx_sync.
  - rx_sync==1: good word; issue a push and go to IDLE.
  - rx_sync==0: discard the word, set frame_err, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_sync==1, then go to IDLE. A held-low line (break) therefore yields exactly one frame_err and no re-triggering.
- Push rule:
  - A push is a single-cycle write in the cycle after the final stop tick.
  - Accepted if rx_full==0, or if rx_full==1 and read_uart==1 in the same cycle (the simultaneous pop frees the slot).
  - Otherwise the word is dropped and overrun is set.
- Pop rule:
  - read_uart with rx_empty==0 advances the head on the next edge.
  - read_uart with rx_empty==1 is ignored and changes no state.
- Simultaneous push and pop on a non-empty FIFO: occupancy is unchanged, and both pointers advance modulo 2^FIFO_EXP.
- Latency: rx_empty deasserts and read_data shows the word 2 clock cycles after the stop-bit sample tick.
- Flags:
  - frame_err and overrun stay set until clr_err or reset.
  - If clr_err coincides with a new error event in the same cycle, set wins.
  - A framing-error word never causes overrun.

Decomposition:
- Shared package uart_pkg holds the FSM state enum {IDLE, START, DATA, STOP, WAIT_IDLE} and the constants for the mid-bit tick (7) and the last oversample tick (15).
- One sub-module: instantiate the team's existing fifo (DATA_SIZE=DBITS, ADDR_SPACE_EXP=FIFO_EXP) as FIFO_RX_UNIT, with the push/pop gating above implemented in uart_rx_core.
- The FSM, synchroniser and flags are local to uart_rx_core.

Test Plan:
- Bench drives sample_tick every 4 clk cycles (one bit = 64 clks).
- Single frame: send 0xA5 (8N1). Required: rx_empty falls 2 clks after the stop-bit sample tick, read_data=0xA5, frame_err=0. Then read_uart pulse -> rx_empty=1.
- Glitch: hold rx low for 5 ticks, then high. Required: FSM returns to IDLE, FIFO stays empty, no flags set.
- Framing error: send 0x3C with the stop bit held low. Required: frame_err=1 and FIFO empty. After rx returns high, send 0x55: it is received correctly and frame_err stays 1 until a clr_err pulse clears it.
- Overrun: send 0x01..0x05 with no reads. Required: rx_full=1 after 4 words, 5th dropped, overrun=1. Four pops return 0x01, 0x02, 0x03, 0x04.
- Full with simultaneous pop: fill 4 words, then pulse read_uart in the push cycle of a 5th word 0x66. Required: no overrun; pops return 0x02, 0x03, 0x04, 0x66.
- Reset mid-frame: assert reset during DATA bit 3. Required: all outputs at reset values. The next full frame 0xF0 is received correctly.
